// File: rtl/writeback_stage.sv
// Writeback stage: selects/extends the writeback value, merges move-wide
// immediates with an internal MOVK bypass, and holds one output entry
// behind a valid/ready handshake.
module writeback_stage #(
  parameter int unsigned WORD      = 64,
  parameter int unsigned INSTR_LEN = 32,
  parameter int unsigned REG_ADDR  = 5,
  parameter int unsigned ZERO_REG  = 31
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INSTR_LEN-1:0] instruction,
  input  logic [1:0]           mem_to_reg,
  input  logic                 reg_write,
  input  logic [REG_ADDR-1:0]  rd,
  input  logic [WORD-1:0]      alu_result,
  input  logic [WORD-1:0]      read_data,
  input  logic [WORD-1:0]      incremented_pc,
  input  logic [WORD-1:0]      read_data2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_reg_write,
  output logic [REG_ADDR-1:0]  out_rd,
  output logic [WORD-1:0]      out_data
);

  localparam logic [10:0] OP_LDURB  = 11'h1C2;
  localparam logic [10:0] OP_LDURH  = 11'h3C2;
  localparam logic [10:0] OP_LDURSW = 11'h5C4;
  localparam logic [8:0]  OP_MOVZ   = 9'h1A5;
  localparam logic [8:0]  OP_MOVN   = 9'h125;
  localparam logic [8:0]  OP_MOVK   = 9'h1E5;

  logic                r_out_valid;
  logic                r_out_reg_write;
  logic [REG_ADDR-1:0] r_out_rd;
  logic [WORD-1:0]     r_out_data;
  logic                r_hist_valid;
  logic [REG_ADDR-1:0] r_hist_rd;
  logic [WORD-1:0]     r_hist_data;

  logic                w_accept;
  logic                w_fire;
  logic [10:0]         w_op11;
  logic [8:0]          w_op9;
  logic [1:0]          w_hw;
  logic [15:0]         w_imm;
  logic [5:0]          w_shamt;
  logic                w_hw_legal;
  logic [WORD-1:0]     w_imm_sh;
  logic [WORD-1:0]     w_mask;
  logic [WORD-1:0]     w_base;
  logic [WORD-1:0]     w_data;
  logic                w_reg_write;

  assign w_accept    = in_valid && in_ready;
  assign w_fire      = r_out_valid && out_ready;
  assign in_ready    = !r_out_valid || out_ready;
  assign w_op11      = instruction[31:21];
  assign w_op9       = instruction[31:23];
  assign w_hw        = instruction[22:21];
  assign w_imm       = instruction[20:5];
  assign w_shamt     = {w_hw, 4'b0000};
  assign w_hw_legal  = (WORD > 32) || !w_hw[1];
  assign w_imm_sh    = WORD'(w_imm) << w_shamt;
  assign w_mask      = WORD'(16'hFFFF) << w_shamt;
  assign w_reg_write = reg_write && (rd != REG_ADDR'(ZERO_REG));

  // MOVK base: held entry first, then last retired write, then regfile operand
  always_comb begin
    w_base = read_data2;
    if (r_out_valid && r_out_reg_write && (r_out_rd == rd)) begin
      w_base = r_out_data;
    end else if (r_hist_valid && (r_hist_rd == rd)) begin
      w_base = r_hist_data;
    end
  end

  // Writeback value: opcode decode overrides the mem_to_reg select
  always_comb begin
    w_data = '0;
    if (w_op11 == OP_LDURB) begin
      w_data = WORD'(read_data[7:0]);
    end else if (w_op11 == OP_LDURH) begin
      w_data = WORD'(read_data[15:0]);
    end else if (w_op11 == OP_LDURSW) begin
      w_data = WORD'($signed(read_data[31:0]));
    end else if (w_op9 == OP_MOVZ) begin
      w_data = w_hw_legal ? w_imm_sh : '0;
    end else if (w_op9 == OP_MOVN) begin
      w_data = w_hw_legal ? ~w_imm_sh : '0;
    end else if (w_op9 == OP_MOVK) begin
      w_data = w_hw_legal ? ((w_base & ~w_mask) | w_imm_sh) : w_base;
    end else begin
      case (mem_to_reg)
        2'd0:    w_data = alu_result;
        2'd1:    w_data = read_data;
        2'd2:    w_data = incremented_pc;
        default: w_data = '0;
      endcase
    end
  end

  // Output entry and single-entry retire history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid     <= 1'b0;
      r_out_reg_write <= 1'b0;
      r_out_rd        <= '0;
      r_out_data      <= '0;
      r_hist_valid    <= 1'b0;
      r_hist_rd       <= '0;
      r_hist_data     <= '0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_hist_valid <= 1'b0;
    end else begin
      if (w_fire && r_out_reg_write) begin
        r_hist_valid <= 1'b1;
        r_hist_rd    <= r_out_rd;
        r_hist_data  <= r_out_data;
      end
      if (w_accept) begin
        r_out_valid     <= 1'b1;
        r_out_reg_write <= w_reg_write;
        r_out_rd        <= rd;
        r_out_data      <= w_data;
      end else if (w_fire) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid     = r_out_valid;
  assign out_reg_write = r_out_reg_write;
  assign out_rd        = r_out_rd;
  assign out_data      = r_out_data;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed literal scenarios plus
// randomized traffic against a behavioural model of the stage.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instruction;
  logic [1:0]  mem_to_reg;
  logic        reg_write;
  logic [4:0]  rd;
  logic [63:0] alu_result, read_data, incremented_pc, read_data2;
  logic        out_valid;
  logic        out_ready;
  logic        out_reg_write;
  logic [4:0]  out_rd;
  logic [63:0] out_data;

  int n_checks = 0;
  int n_fail   = 0;

  // model: one held entry plus the last retired write
  bit          m_valid, m_wr, h_valid;
  logic [4:0]  m_rd, h_rd;
  logic [63:0] m_data, h_data;

  writeback_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .rd(rd),
    .alu_result(alu_result), .read_data(read_data),
    .incremented_pc(incremented_pc), .read_data2(read_data2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_reg_write(out_reg_write), .out_rd(out_rd), .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_mw(input logic [8:0] opc, input logic [1:0] hw,
                                        input logic [15:0] imm, input logic [4:0] r);
    return {opc, hw, imm, r};
  endfunction

  // Architectural value of an entry, from the instruction semantics
  function automatic logic [63:0] model_value(input logic [31:0] ins, input logic [1:0] sel,
      input logic [63:0] alu, input logic [63:0] mem, input logic [63:0] pc, input logic [63:0] base);
    logic [10:0] op11;
    logic [8:0]  op9;
    logic [63:0] place, sh;
    op11  = ins[31:21];
    op9   = ins[31:23];
    place = 64'd1 << (16 * ins[22:21]);
    sh    = 64'(ins[20:5]) * place;
    if (op11 == 11'h1C2) return mem % 64'd256;
    if (op11 == 11'h3C2) return mem % 64'd65536;
    if (op11 == 11'h5C4) return mem[31] ? (64'hFFFF_FFFF_0000_0000 + 64'(mem[31:0])) : 64'(mem[31:0]);
    if (op9 == 9'h1A5) return sh;
    if (op9 == 9'h125) return ~sh;
    if (op9 == 9'h1E5) return base - (((base / place) % 64'd65536) * place) + sh;
    case (sel)
      2'd0: return alu;
      2'd1: return mem;
      2'd2: return pc;
      default: return 64'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 0; m_wr = 0; m_rd = '0; m_data = '0;
    h_valid = 0; h_rd = '0; h_data = '0;
  endtask

  task automatic drive(input bit iv, input logic [31:0] ins, input logic [1:0] sel,
                       input bit wr, input logic [4:0] r, input logic [63:0] alu,
                       input logic [63:0] mem, input logic [63:0] pc, input logic [63:0] b2,
                       input bit ordy, input bit fl);
    in_valid = iv; instruction = ins; mem_to_reg = sel; reg_write = wr; rd = r;
    alu_result = alu; read_data = mem; incremented_pc = pc; read_data2 = b2;
    out_ready = ordy; flush = fl;
  endtask

  // Advance one clock, step the model with the pre-edge inputs, compare at negedge
  task automatic cycle();
    bit          acc, fire;
    logic [63:0] base, val;
    acc  = in_valid && (!m_valid || out_ready);
    fire = m_valid && out_ready;
    if (m_valid && m_wr && m_rd == rd) base = m_data;
    else if (h_valid && h_rd == rd)    base = h_data;
    else                               base = read_data2;
    val = model_value(instruction, mem_to_reg, alu_result, read_data, incremented_pc, base);
    @(posedge clk);
    if (flush) begin
      m_valid = 0; h_valid = 0;
    end else begin
      if (fire && m_wr) begin h_valid = 1; h_rd = m_rd; h_data = m_data; end
      if (acc) begin
        m_valid = 1; m_wr = reg_write && (rd != 5'd31); m_rd = rd; m_data = val;
      end else if (fire) begin
        m_valid = 0;
      end
    end
    @(negedge clk);
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("in_ready", 64'(in_ready), 64'(!m_valid || out_ready));
    if (m_valid) begin
      chk("out_rd", 64'(out_rd), 64'(m_rd));
      chk("out_reg_write", 64'(out_reg_write), 64'(m_wr));
      chk("out_data", out_data, m_data);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_wr"}, 64'(out_reg_write), 64'd0);
    chk({tag, "_rd"}, 64'(out_rd), 64'd0);
    chk({tag, "_data"}, out_data, 64'd0);
  endtask

  task automatic random_drive();
    logic [31:0] ins;
    logic [4:0]  r;
    int k;
    k = $urandom_range(0, 4);
    r = (k == 0) ? 5'd3 : (k <= 2) ? 5'd5 : (k == 3) ? 5'd31 : 5'($urandom);
    case ($urandom_range(0, 7))
      0: ins = {11'h1C2, 21'($urandom)};
      1: ins = {11'h3C2, 21'($urandom)};
      2: ins = {11'h5C4, 21'($urandom)};
      3: ins = mk_mw(9'h1A5, 2'($urandom), 16'($urandom), r);
      4: ins = mk_mw(9'h125, 2'($urandom), 16'($urandom), r);
      5, 6: ins = mk_mw(9'h1E5, 2'($urandom), 16'($urandom), r);
      default: ins = {11'h458, 21'($urandom)};
    endcase
    drive($urandom_range(0, 9) < 7, ins, 2'($urandom), $urandom_range(0, 9) < 9, r,
          {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
          {$urandom, $urandom}, $urandom_range(0, 9) < 7, $urandom_range(0, 31) == 0);
  endtask

  localparam logic [31:0] ADD = {11'h458, 21'h0};

  initial begin
    model_reset();
    rst_n = 1'b0;
    drive(0, 32'h0, 2'd0, 0, 5'd0, 64'd0, 64'd0, 64'd0, 64'd0, 1, 0);
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;

    // ADD result passes through after one edge
    drive(1, ADD, 2'd0, 1, 5'd3, 64'h1234, 64'd0, 64'd0, 64'd0, 1, 0);
    cycle();
    chk("add_lit", out_data, 64'h1234);
    chk("add_rd_lit", 64'(out_rd), 64'd3);
    // Load extensions
    drive(1, {11'h5C4, 21'h0}, 2'd1, 1, 5'd4, 64'd0, 64'h0000_0000_8000_0001, 64'd0, 64'd0, 1, 0);
    cycle();
    chk("ldursw_lit", out_data, 64'hFFFF_FFFF_8000_0001);
    drive(1, {11'h1C2, 21'h0}, 2'd1, 1, 5'd6, 64'd0, 64'h1234_56FF, 64'd0, 64'd0, 1, 0);
    cycle();
    chk("ldurb_lit", out_data, 64'h0000_0000_0000_00FF);
    // MOVZ then MOVK while the MOVZ is held: bypass from the output register
    drive(1, mk_mw(9'h1A5, 2'd1, 16'hBEEF, 5'd5), 2'd0, 1, 5'd5, 64'd0, 64'd0, 64'd0, 64'd0, 1, 0);
    cycle();
    drive(1, mk_mw(9'h1E5, 2'd0, 16'hCAFE, 5'd5), 2'd0, 1, 5'd5, 64'd0, 64'd0, 64'd0, 64'd0, 0, 0);
    cycle();
    chk("stall_in_ready_lit", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    cycle();
    chk("movk_held_lit", out_data, 64'h0000_0000_BEEF_CAFE);
    // Retire it, then MOVK hits the history
    drive(0, ADD, 2'd0, 1, 5'd5, 64'd0, 64'd0, 64'd0, 64'd0, 1, 0);
    cycle();
    drive(1, mk_mw(9'h1E5, 2'd3, 16'h1111, 5'd5), 2'd0, 1, 5'd5, 64'd0, 64'd0, 64'd0, 64'd0, 1, 0);
    cycle();
    chk("movk_hist_lit", out_data, 64'h1111_0000_BEEF_CAFE);
    // Back-pressure for three cycles, then release
    drive(1, ADD, 2'd2, 1, 5'd7, 64'd0, 64'd0, 64'h400, 64'd0, 0, 0);
    repeat (3) cycle();
    chk("held_data_lit", out_data, 64'h1111_0000_BEEF_CAFE);
    out_ready = 1'b1;
    cycle();
    chk("released_lit", out_data, 64'h400);
    // XZR entry, then flush of a pending entry
    drive(1, ADD, 2'd0, 1, 5'd31, 64'h99, 64'd0, 64'd0, 64'd0, 1, 0);
    cycle();
    chk("xzr_wr_lit", 64'(out_reg_write), 64'd0);
    drive(1, ADD, 2'd0, 1, 5'd5, 64'h77, 64'd0, 64'd0, 64'd0, 0, 0);
    cycle();
    drive(0, ADD, 2'd0, 1, 5'd5, 64'h77, 64'd0, 64'd0, 64'd0, 0, 1);
    cycle();
    chk("flush_valid_lit", 64'(out_valid), 64'd0);
    drive(1, mk_mw(9'h1E5, 2'd0, 16'h2222, 5'd5), 2'd0, 1, 5'd5, 64'd0, 64'd0, 64'd0,
          64'hAAAA_AAAA_AAAA_AAAA, 1, 0);
    cycle();
    chk("movk_after_flush_lit", out_data, 64'hAAAA_AAAA_AAAA_2222);

    // Randomized traffic with one asynchronous reset mid-transaction
    for (int i = 0; i < 3000; i++) begin
      random_drive();
      if (i == 1500) begin
        in_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        chk_reset_outputs("post_reset");
      end else begin
        cycle();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Registered, parametrised writeback stage for the pipelined LEGv8 core.
- Sits between the MEM/WB boundary and the register file.
- Selects the writeback source (ALU, memory, PC+4 or move-wide), size-extends loads, and merges MOVK/MOVZ/MOVN immediates.
- Adds a valid/ready handshake, a one-entry output register, flush support, and an internal MOVK bypass so back-to-back move-wide sequences on one register merge correctly without regfile forwarding.

Parameters:
- WORD, 64, datapath width in bits; legal values 32 or 64.
- INSTR_LEN, 32, instruction width.
- REG_ADDR, 5, register index width.
- ZERO_REG, 31, register index whose writes are suppressed (XZR).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; kills the held output entry and the bypass history.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept an entry.
- instruction  in  INSTR_LEN  instruction of the entry.
- mem_to_reg  in  2  source select: 0 ALU, 1 memory, 2 incremented PC, 3 reserved.
- reg_write  in  1  entry writes a register.
- rd  in  REG_ADDR  destination register.
- alu_result, read_data, incremented_pc, read_data2  in  WORD  source operands.
- out_valid  out  1  writeback entry valid.
- out_ready  in  1  register file accepts the entry.
- out_reg_write  out  1  write enable; 0 when rd == ZERO_REG.
- out_rd  out  REG_ADDR  destination register.
- out_data  out  WORD  value to write.

Behaviour:
- **Reset** (rst_n low, asynchronous): out_valid=0, out_reg_write=0, out_rd=0, out_data=0, bypass history invalid. in_ready=1 after reset.
- **Handshake:**
  - in_ready = !out_valid || out_ready.
  - An entry is accepted when in_valid && in_ready. It is registered and appears on the outputs at the next edge (latency 1).
  - Output fires when out_valid && out_ready. If there is a fire and no accept on the same edge, out_valid drops to 0.
  - Outputs hold stable while out_valid && !out_ready.
- **Opcode decode** (instruction[31:21], same opcode constants as the core) takes priority over mem_to_reg:
  - LDURB: zero-extend read_data[7:0].
  - LDURH: zero-extend read_data[15:0].
  - LDURSW: sign-extend read_data[31:0]. When WORD=32, pass read_data unchanged.
  - MOVZ: imm16 = instruction[20:5], hw = instruction[22:21]; value = imm16 << (16*hw), all other bits 0.
  - MOVN: bitwise NOT of the MOVZ value.
  - MOVK: base with bits [16*hw +: 16] replaced by imm16. base is selected per the bypass rules.
  - Otherwise, by mem_to_reg: 0 alu_result, 1 read_data, 2 incremented_pc, 3 all-zero.
- **Move-wide shift limits:**
  - hw values whose shift is ≥ WORD (hw ≥ 2 when WORD=32) are illegal.
  - For an illegal hw, out_data = base for MOVK and 0 for MOVZ/MOVN.
- **MOVK base priority**, evaluated at accept:
  1. Held output entry: out_valid && out_reg_write && out_rd==rd → out_data.
  2. Last retired entry: hist_valid && hist_rd==rd → hist_data.
  3. Otherwise read_data2.
  - The history register updates on each output fire that has out_reg_write=1, capturing rd and data. It holds a single entry.
  - If a fire and an accept with a matching rd occur on the same edge, priority 1 applies using the pre-edge out_data.
- **ZERO_REG:** an entry with rd == ZERO_REG propagates with out_reg_write=0 and never enters the history.
- **flush:** the next edge sets out_valid=0 and hist_valid=0, overriding any simultaneous accept. in_ready is unaffected.
- **reset mid-transaction:** the entry is dropped with no partial write.

Test Plan:
- After reset, in_valid=1, instruction=ADD, mem_to_reg=0, alu_result=0x1234, rd=3, out_ready=1 → next cycle out_valid=1, out_rd=3, out_data=0x1234, out_reg_write=1.
- LDURSW with read_data=0x00000000_80000001 → out_data=0xFFFFFFFF_80000001. LDURB with read_data=0xFF → 0x00000000_000000FF.
- Back-to-back MOVZ X5,#0xBEEF,LSL#16, then MOVK X5,#0xCAFE,LSL#0, with read_data2=0 and out_ready held 0 for the first cycle → second entry's out_data=0x00000000_BEEFCAFE (bypass from the held entry).
- MOVK X5,#0x1111,LSL#48 one cycle after the prior X5 entry retired, read_data2=0 → out_data=0x1111_0000_BEEF_CAFE (history bypass).
- out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and outputs stable. out_ready=1 → next entry accepted that edge.
- Entry with rd=31, then flush asserted with a pending output → out_reg_write=0 for rd 31. After flush: out_valid=0, and a following MOVK uses read_data2.
